// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles the two requester command/response channels and the RAM strobe
//   bus shared by ram_arbiter.
//   Requester A/B: req, we, addr, wdata (to arbiter); gnt, done, rdata (back).
//   RAM side: cs, w, oe, add, i (to RAM); o (read data from RAM).
//   Modport slave is the arbiter's view; modport master is the view of the
//   environment (requesters plus RAM).
interface ram_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_done;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_done;
    logic [DW-1:0] b_rdata;

    logic          ram_cs;
    logic          ram_w;
    logic          ram_oe;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_i;
    logic [DW-1:0] ram_o;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_done, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_done, b_rdata,
        output ram_cs, ram_w, ram_oe, ram_add, ram_i,
        input  ram_o
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_done, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_done, b_rdata,
        input  ram_cs, ram_w, ram_oe, ram_add, ram_i,
        output ram_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Round-robin arbiter/sequencer sharing one single-port synchronous RAM
//   (registered read data, output enable) between requesters A and B.
//   One command is latched per grant; writes take ACCESS only, reads take
//   ACCESS then CAPTURE. A completion pulse (done) returns to the owner in the
//   IDLE cycle that follows, together with read data for reads.
// Ports
//   c    : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : ram_arbiter_if.slave -- requester A/B channels and RAM strobes
// All outputs are registered; they are computed from the next state.
module ram_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic           c,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;   // 1: B was served last
    logic          owner_q, owner_d;     // 0: A, 1: B
    logic          we_q, we_d;

    logic          a_gnt_q, a_gnt_d;
    logic          b_gnt_q, b_gnt_d;
    logic          a_done_q, a_done_d;
    logic          b_done_q, b_done_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    logic          ram_cs_q, ram_cs_d;
    logic          ram_w_q, ram_w_d;
    logic          ram_oe_q, ram_oe_d;
    logic [AW-1:0] ram_add_q, ram_add_d;
    logic [DW-1:0] ram_i_q, ram_i_d;

    logic          pick_b;

    // B wins when it is the only requester, or on a tie when A was served last.
    assign pick_b = bus.b_req & (~bus.a_req | ~last_b_q);

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        owner_d   = owner_q;
        we_d      = we_q;
        a_gnt_d   = 1'b0;
        b_gnt_d   = 1'b0;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        ram_cs_d  = 1'b0;
        ram_w_d   = 1'b0;
        ram_oe_d  = 1'b0;
        ram_add_d = ram_add_q;
        ram_i_d   = ram_i_q;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    owner_d  = pick_b;
                    last_b_d = pick_b;
                    a_gnt_d  = ~pick_b;
                    b_gnt_d  = pick_b;
                    we_d     = pick_b ? bus.b_we : bus.a_we;
                    // Address/data go straight into the RAM-facing registers so
                    // they are already on the bus during the ACCESS cycle.
                    ram_add_d = pick_b ? bus.b_addr : bus.a_addr;
                    if (we_d) begin
                        ram_i_d = pick_b ? bus.b_wdata : bus.a_wdata;
                    end
                    ram_cs_d = 1'b1;
                    ram_w_d  = we_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    // RAM commits at the end of ACCESS; report completion next.
                    a_done_d = ~owner_q;
                    b_done_d = owner_q;
                    state_d  = IDLE;
                end else begin
                    // RAM registered mem[addr]; enable its output for one cycle.
                    ram_cs_d = 1'b1;
                    ram_oe_d = 1'b1;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (owner_q) begin
                    b_rdata_d = bus.ram_o;
                    b_done_d  = 1'b1;
                end else begin
                    a_rdata_d = bus.ram_o;
                    a_done_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            ram_cs_q  <= 1'b0;
            ram_w_q   <= 1'b0;
            ram_oe_q  <= 1'b0;
            ram_add_q <= '0;
            ram_i_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            ram_cs_q  <= ram_cs_d;
            ram_w_q   <= ram_w_d;
            ram_oe_q  <= ram_oe_d;
            ram_add_q <= ram_add_d;
            ram_i_q   <= ram_i_d;
        end
    end

    assign bus.a_gnt   = a_gnt_q;
    assign bus.b_gnt   = b_gnt_q;
    assign bus.a_done  = a_done_q;
    assign bus.b_done  = b_done_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.ram_cs  = ram_cs_q;
    assign bus.ram_w   = ram_w_q;
    assign bus.ram_oe  = ram_oe_q;
    assign bus.ram_add = ram_add_q;
    assign bus.ram_i   = ram_i_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural 8x8 synchronous RAM
//   (registered read, output floats to 0xEE when oe is low).
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;

    logic c;
    logic rst;
    int   checks;
    int   errors;
    int   overlap_cnt;
    int   b_done_cnt;

    ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // RAM model: unwritten word k reads back 0xA0+k.
    logic [DW-1:0] mem [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    logic [DW-1:0] rd_q;

    always @(posedge c) begin
        if (bus.ram_cs && bus.ram_w) mem[bus.ram_add] <= bus.ram_i;
        if (bus.ram_cs && !bus.ram_w) rd_q <= mem[bus.ram_add];
    end
    assign bus.ram_o = bus.ram_oe ? rd_q : 8'hEE;

    always @(negedge c) begin
        if (!rst) begin
            if (bus.ram_oe && bus.ram_w) overlap_cnt++;
            if (bus.b_done) b_done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd;
    endtask

    initial begin
        checks = 0; errors = 0; overlap_cnt = 0; b_done_cnt = 0;
        rst = 1'b1;
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        do_reset();

        // reset state
        chk("rst_cs",    bus.ram_cs,  1'b0);
        chk("rst_w",     bus.ram_w,   1'b0);
        chk("rst_oe",    bus.ram_oe,  1'b0);
        chk("rst_add",   bus.ram_add, 3'd0);
        chk("rst_i",     bus.ram_i,   8'h00);
        chk("rst_gnt",   {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}, 4'b0000);
        chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 16'h0000);

        // 1: A write 0x22 @1
        set_a(1'b1, 1'b1, 3'd1, 8'h22);
        tick();
        chk("t1_gnt",  {bus.a_gnt, bus.b_gnt}, 2'b10);
        chk("t1_strb", {bus.ram_cs, bus.ram_w, bus.ram_oe}, 3'b110);
        chk("t1_add",  bus.ram_add, 3'd1);
        chk("t1_i",    bus.ram_i, 8'h22);
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        chk("t1_done", {bus.a_done, bus.b_done, bus.a_gnt}, 3'b100);
        chk("t1_idle", {bus.ram_cs, bus.ram_w, bus.ram_oe}, 3'b000);
        chk("t1_hold", {bus.ram_add, bus.ram_i}, {3'd1, 8'h22});
        tick();
        chk("t1_pulse", bus.a_done, 1'b0);

        // 2: A read @1
        set_a(1'b1, 1'b0, 3'd1, 8'h00);
        tick();
        chk("t2_gnt",  bus.a_gnt, 1'b1);
        chk("t2_acc",  {bus.ram_cs, bus.ram_w, bus.ram_oe}, 3'b100);
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        chk("t2_cap",  {bus.ram_cs, bus.ram_w, bus.ram_oe}, 3'b101);
        chk("t2_capd", {bus.a_gnt, bus.a_done, bus.ram_add}, {2'b00, 3'd1});
        tick();
        chk("t2_done", {bus.a_done, bus.ram_oe, bus.ram_cs}, 3'b100);
        chk("t2_data", bus.a_rdata, 8'h22);

        // 3: tie after reset -> A, then B, then A again
        do_reset();
        set_a(1'b1, 1'b1, 3'd2, 8'h11);
        set_b(1'b1, 1'b1, 3'd4, 8'h44);
        tick();
        chk("t3_g1", {bus.a_gnt, bus.b_gnt, bus.ram_add}, {2'b10, 3'd2});
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        chk("t3_d1", {bus.a_done, bus.b_gnt}, 2'b10);
        tick();
        chk("t3_g2", {bus.a_gnt, bus.b_gnt, bus.ram_add, bus.ram_i}, {2'b01, 3'd4, 8'h44});
        set_a(1'b1, 1'b1, 3'd5, 8'h55);
        tick();
        chk("t3_d2", {bus.b_done, bus.a_gnt}, 2'b10);
        tick();
        chk("t3_g3", {bus.a_gnt, bus.b_gnt, bus.ram_add}, {2'b10, 3'd5});
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        set_b(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();

        // 4: B write 0x5A @7, A read @7
        set_b(1'b1, 1'b1, 3'd7, 8'h5A);
        tick();
        chk("t4_bg", {bus.b_gnt, bus.ram_w, bus.ram_i}, {2'b11, 8'h5A});
        set_b(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        set_a(1'b1, 1'b0, 3'd7, 8'h00);
        tick();
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("t4_a", {bus.a_done, bus.a_rdata}, {1'b1, 8'h5A});
        chk("t4_b", bus.b_rdata, 8'h00);

        // 5: A read of unwritten @3, B quiet
        b_done_cnt = 0;
        set_a(1'b1, 1'b0, 3'd3, 8'h00);
        tick();
        chk("t5_acc", {bus.ram_oe, bus.ram_w}, 2'b00);
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("t5_data", {bus.a_done, bus.a_rdata}, {1'b1, 8'hA3});
        tick();
        chk("t5_oe", bus.ram_oe, 1'b0);
        chk("t5_bdone", b_done_cnt, 0);

        // 6: reset during CAPTURE of A read, then B read
        set_a(1'b1, 1'b0, 3'd1, 8'h00);
        tick();
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        chk("t6_cap", bus.ram_oe, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_rst", {bus.ram_cs, bus.ram_w, bus.ram_oe, bus.a_done}, 4'b0000);
        rst = 1'b0;
        tick();
        chk("t6_nodone", {bus.a_done, bus.a_rdata}, {1'b0, 8'h00});
        set_b(1'b1, 1'b0, 3'd7, 8'h00);
        tick();
        chk("t6_bg", {bus.b_gnt, bus.a_gnt, bus.ram_add}, {2'b10, 3'd7});
        set_b(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("t6_bd", {bus.b_done, bus.b_rdata, bus.a_rdata}, {1'b1, 8'h5A, 8'h00});

        chk("oe_w_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
